// File: rtl/four_input_adder_arb.sv
// Round-robin arbiter that shares one registered four-operand adder among _N requesters.
// Optional macro FOUR_INPUT_ADDER_ARB_SAT_EN: saturate rsp_sum to all ones on adder overflow.
module four_input_adder_arb #(
  parameter  int _W   = 32,
  parameter  int _N   = 4,
  localparam int _IDW = $clog2(_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [_N-1:0]     req_vld,
  output logic [_N-1:0]     req_rdy,
  input  logic [_N*_W-1:0]  req_a0,
  input  logic [_N*_W-1:0]  req_a1,
  input  logic [_N*_W-1:0]  req_a2,
  input  logic [_N*_W-1:0]  req_a3,
  output logic              add_en,
  output logic [_W-1:0]     add_a0,
  output logic [_W-1:0]     add_a1,
  output logic [_W-1:0]     add_a2,
  output logic [_W-1:0]     add_a3,
  input  logic [_W-1:0]     add_b,
  input  logic              add_O_F,
  input  logic              add_vld,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [_IDW-1:0]   rsp_id,
  output logic [_W-1:0]     rsp_sum,
  output logic              rsp_ovf,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [_IDW-1:0]  r_rr_ptr;
  logic [_IDW-1:0]  r_id;
  logic [_W-1:0]    r_op0;
  logic [_W-1:0]    r_op1;
  logic [_W-1:0]    r_op2;
  logic [_W-1:0]    r_op3;
  logic [_W-1:0]    r_rsp_sum;
  logic             r_rsp_ovf;
  logic             r_err;

  logic             w_found;
  logic [_IDW-1:0]  w_win;
  logic             w_grant;
  logic [_N-1:0]    w_req_rdy;
  logic             w_add_en;
  logic             w_rsp_vld;
  logic             w_rsp_fire;
  logic             w_capture;
  logic [_W-1:0]    w_cap_sum;
  logic [_IDW-1:0]  w_ptr_nxt;

  // Winner search starts at r_rr_ptr and wraps modulo _N.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < _N; i++) begin
      if (!w_found && req_vld[_IDW'((int'(r_rr_ptr) + i) % _N)]) begin
        w_found = 1'b1;
        w_win   = _IDW'((int'(r_rr_ptr) + i) % _N);
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; req_rdy is offered only in IDLE, and rsp_vld holds with stable
  // id/sum/ovf until rsp_rdy is seen.
  assign w_grant    = rst_n && (r_state == S_IDLE) && w_found;
  assign w_rsp_fire = (r_state == S_RESP) && rsp_rdy;
  assign w_capture  = (r_state == S_WAIT) && add_vld;
  assign w_ptr_nxt  = (r_id == _IDW'(_N - 1)) ? '0 : r_id + 1'b1;

  always_comb begin
    w_req_rdy = '0;
    if (w_grant) begin
      w_req_rdy[w_win] = 1'b1;
    end
  end

`ifdef FOUR_INPUT_ADDER_ARB_SAT_EN
  assign w_cap_sum = add_O_F ? {_W{1'b1}} : add_b;
`else
  assign w_cap_sum = add_b;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_add_en    = 1'b0;
    w_rsp_vld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_add_en    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (add_vld) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_vld = 1'b1;
        if (rsp_rdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_op0     <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_op3     <= '0;
      r_rsp_sum <= '0;
      r_rsp_ovf <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_op0 <= req_a0[int'(w_win) * _W +: _W];
        r_op1 <= req_a1[int'(w_win) * _W +: _W];
        r_op2 <= req_a2[int'(w_win) * _W +: _W];
        r_op3 <= req_a3[int'(w_win) * _W +: _W];
        r_id  <= w_win;
      end
      if (w_capture) begin
        r_rsp_sum <= w_cap_sum;
        r_rsp_ovf <= add_O_F;
      end
      if (w_rsp_fire) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      // A result outside WAIT is a protocol violation; it is flagged and dropped.
      if (add_vld && (r_state != S_WAIT)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_rdy = w_req_rdy;
  assign add_en  = w_add_en;
  assign add_a0  = r_op0;
  assign add_a1  = r_op1;
  assign add_a2  = r_op2;
  assign add_a3  = r_op3;
  assign rsp_vld = w_rsp_vld;
  assign rsp_id  = r_id;
  assign rsp_sum = r_rsp_sum;
  assign rsp_ovf = r_rsp_ovf;
  assign err     = r_err;

endmodule

// File: tb/tb_four_input_adder_arb.sv
// Bench for four_input_adder_arb: behavioural adder, accept-time scoreboard,
// vector table plus timing, round-robin, backpressure, stray-valid and reset sequences.
module tb_four_input_adder_arb;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int EW  = IDW + 1 + W;
`ifdef FOUR_INPUT_ADDER_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic [N*W-1:0]  req_a0, req_a1, req_a2, req_a3;
  logic            add_en;
  logic [W-1:0]    add_a0, add_a1, add_a2, add_a3;
  logic [W-1:0]    add_b;
  logic            add_O_F;
  logic            add_vld;
  logic            m_vld;
  logic            stray;
  logic            rsp_vld;
  logic            rsp_rdy;
  logic [IDW-1:0]  rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_ovf;
  logic            err;
  logic [W+1:0]    m_full;

  always #5 clk = ~clk;

  four_input_adder_arb #(._W(W), ._N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a0(req_a0), .req_a1(req_a1), .req_a2(req_a2), .req_a3(req_a3),
    .add_en(add_en), .add_a0(add_a0), .add_a1(add_a1), .add_a2(add_a2), .add_a3(add_a3),
    .add_b(add_b), .add_O_F(add_O_F), .add_vld(add_vld),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_ovf(rsp_ovf), .err(err)
  );

  function automatic logic [W+1:0] add4(input logic [W-1:0] a, b, c, d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

  function automatic logic [W-1:0] exp_sum(input logic [W+1:0] full);
    if (SAT && (|full[W+1:W])) return {W{1'b1}};
    return full[W-1:0];
  endfunction

  // Behavioural registered adder: result one cycle after add_en.
  assign m_full  = add4(add_a0, add_a1, add_a2, add_a3);
  assign add_vld = m_vld | stray;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld   <= 1'b0;
      add_b   <= '0;
      add_O_F <= 1'b0;
    end else begin
      m_vld <= add_en;
      if (add_en) begin
        add_b   <= m_full[W-1:0];
        add_O_F <= |m_full[W+1:W];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : push_blk
    int k;
    logic [W+1:0] f;
    if (rst_n && req_rdy != '0) begin
      k = 0;
      for (int i = 0; i < N; i++) if (req_rdy[i]) k = i;
      check("req_rdy_onehot", 64'($onehot(req_rdy)), 64'd1);
      f = add4(req_a0[k*W +: W], req_a1[k*W +: W], req_a2[k*W +: W], req_a3[k*W +: W]);
      exp_q.push_back({IDW'(k), |f[W+1:W], exp_sum(f)});
    end
  end

  always @(negedge clk) begin : pop_blk
    logic [EW-1:0] e;
    if (rst_n && rsp_vld && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp_id", 64'(rsp_id), 64'(e[EW-1 -: IDW]));
        check("sb_rsp_ovf", 64'(rsp_ovf), 64'(e[W]));
        check("sb_rsp_sum", 64'(rsp_sum), 64'(e[W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [W-1:0] a0, a1, a2, a3);
    req_a0[k*W +: W] = a0;
    req_a1[k*W +: W] = a1;
    req_a2[k*W +: W] = a2;
    req_a3[k*W +: W] = a3;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic request(input int k, input logic [W-1:0] a0, a1, a2, a3);
    logic ok;
    ok = 1'b0;
    set_op(k, a0, a1, a2, a3);
    req_vld[k] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_rdy[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", 64'(ok), 64'd1);
    tick();
    req_vld[k] = 1'b0;
  endtask

  task automatic wait_rsp();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_vld) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_arrive", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_grant(input int k);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_rdy[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_wait", 64'(ok), 64'd1);
    tick();
    req_vld[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    req_vld = '0;
    stray = 1'b0;
    rsp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         k;
    logic [W-1:0] a0, a1, a2, a3;
    logic [W-1:0] sum;
    logic         ovf;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ngr, nen, prev, idx;
    logic [W-1:0] es;

    tbl[0] = '{0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 1'b0};
    tbl[1] = '{1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
    tbl[2] = '{3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h0000_0000, 1'b1};
    tbl[3] = '{2, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1};
    tbl[4] = '{1, 32'd10, 32'd20, 32'd30, 32'd40, 32'd100, 1'b0};
    tbl[5] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1};
    tbl[6] = '{0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h8000_0000, 1'b0};

    req_a0 = '0; req_a1 = '0; req_a2 = '0; req_a3 = '0;
    stray = 1'b0;
    rsp_rdy = 1'b1;
    rst_n = 1'b0;
    req_vld = '1;
    #2;
    // Reset state, with requests pending during reset.
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_add_en", 64'(add_en), 64'd0);
    check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    do_reset();

    // Single request timing: requester 2, operands 1,2,3,4.
    set_op(2, 32'd1, 32'd2, 32'd3, 32'd4);
    req_vld[2] = 1'b1;
    @(negedge clk);
    check("t_req_rdy", 64'(req_rdy), 64'b0100);
    check("t_add_en0", 64'(add_en), 64'd0);
    tick();
    req_vld[2] = 1'b0;
    @(negedge clk);
    check("t_add_en1", 64'(add_en), 64'd1);
    check("t_req_rdy_off", 64'(req_rdy), 64'd0);
    check("t_add_a0", 64'(add_a0), 64'd1);
    check("t_add_a1", 64'(add_a1), 64'd2);
    check("t_add_a2", 64'(add_a2), 64'd3);
    check("t_add_a3", 64'(add_a3), 64'd4);
    tick();
    @(negedge clk);
    check("t_add_en2", 64'(add_en), 64'd0);
    check("t_rsp_early", 64'(rsp_vld), 64'd0);
    tick();
    @(negedge clk);
    check("t_rsp_vld", 64'(rsp_vld), 64'd1);
    check("t_rsp_id", 64'(rsp_id), 64'd2);
    check("t_rsp_sum", 64'(rsp_sum), 64'd10);
    check("t_rsp_ovf", 64'(rsp_ovf), 64'd0);
    tick();
    @(negedge clk);
    check("t_rsp_done", 64'(rsp_vld), 64'd0);
    check("t_a0_hold", 64'(add_a0), 64'd1);
    tick();

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      request(tbl[i].k, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3);
      wait_rsp();
      es = (SAT && tbl[i].ovf) ? {W{1'b1}} : tbl[i].sum;
      check("v_rsp_id", 64'(rsp_id), 64'(tbl[i].k));
      check("v_rsp_sum", 64'(rsp_sum), 64'(es));
      check("v_rsp_ovf", 64'(rsp_ovf), 64'(tbl[i].ovf));
      tick();
    end

    // Random vectors, checked by the scoreboard.
    for (int i = 0; i < 8; i++) begin
      request(int'($urandom_range(0, N - 1)), $urandom,
              ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom,
              $urandom, $urandom_range(0, 255));
      wait_rsp();
      tick();
    end
    drain();

    // Round-robin with all requesters held.
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, 32'(k + 1), 32'(100 * k), 32'd7, 32'(k));
    req_vld = '1;
    ngr = 0; nen = 0; prev = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (add_en) nen++;
      if (req_rdy != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (req_rdy[i]) idx = i;
        check("rr_order", 64'(idx), 64'(ngr % N));
        if (ngr > 0) check("rr_spacing", 64'(c - prev), 64'd4);
        prev = c;
        ngr++;
        if (ngr == 5) break;
      end
    end
    check("rr_grants", 64'(ngr), 64'd5);
    tick();
    req_vld = '0;
    @(negedge clk);
    if (add_en) nen++;
    check("rr_add_en_count", 64'(nen), 64'd5);
    drain();
    tick();

    // Response backpressure; pointer is now 1.
    rsp_rdy = 1'b0;
    set_op(0, 32'd1, 32'd1, 32'd1, 32'd1);
    set_op(1, 32'd5, 32'd6, 32'd7, 32'd8);
    set_op(3, 32'd2, 32'd2, 32'd2, 32'd2);
    req_vld = 4'b1011;
    @(negedge clk);
    check("bp_first_grant", 64'(req_rdy), 64'b0010);
    tick();
    req_vld[1] = 1'b0;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_vld", 64'(rsp_vld), 64'd1);
      check("bp_rsp_id", 64'(rsp_id), 64'd1);
      check("bp_rsp_sum", 64'(rsp_sum), 64'd26);
      check("bp_req_rdy", 64'(req_rdy), 64'd0);
      tick();
      @(negedge clk);
    end
    tick();
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("bp_hs_rsp_vld", 64'(rsp_vld), 64'd1);
    check("bp_hs_req_rdy", 64'(req_rdy), 64'd0);
    tick();
    @(negedge clk);
    check("bp_next_grant", 64'(req_rdy), 64'b1000);
    tick();
    req_vld[3] = 1'b0;
    wait_grant(0);
    drain();
    tick();

    // Stray adder valid while idle.
    @(negedge clk);
    check("st_err_pre", 64'(err), 64'd0);
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("st_err_sticky", 64'(err), 64'd1);
      check("st_no_rsp", 64'(rsp_vld), 64'd0);
      tick();
    end
    request(2, 32'h11, 32'h22, 32'h33, 32'h44);
    wait_rsp();
    check("st_rsp_sum", 64'(rsp_sum), 64'hAA);
    check("st_rsp_id", 64'(rsp_id), 64'd2);
    check("st_err_kept", 64'(err), 64'd1);
    tick();
    drain();

    // Reset while in WAIT.
    request(1, 32'd9, 32'd9, 32'd9, 32'd9);
    @(negedge clk);
    check("rm_add_en", 64'(add_en), 64'd1);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rm_add_a0", 64'(add_a0), 64'd0);
    check("rm_add_a3", 64'(add_a3), 64'd0);
    check("rm_add_en0", 64'(add_en), 64'd0);
    check("rm_rsp_vld", 64'(rsp_vld), 64'd0);
    check("rm_rsp_id", 64'(rsp_id), 64'd0);
    check("rm_rsp_sum", 64'(rsp_sum), 64'd0);
    check("rm_rsp_ovf", 64'(rsp_ovf), 64'd0);
    check("rm_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rm_discard", 64'(rsp_vld), 64'd0);
    tick();
    set_op(0, 32'd3, 32'd0, 32'd0, 32'd0);
    set_op(3, 32'd4, 32'd0, 32'd0, 32'd0);
    req_vld = 4'b1001;
    @(negedge clk);
    check("rm_grant0", 64'(req_rdy), 64'b0001);
    tick();
    req_vld[0] = 1'b0;
    wait_grant(3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
